vdp_host_bus_if: RTL and testbench

Host-CPU bus front end for the V9958 core. It sits between the TMS9900-style strobes (csr_n, csw_n, mode, cd) and the VDP core's REQ/WRT/ADR/DBO/DBI/ACK port.
- Synchronizes and glitch-filters the strobes.
- Converts each strobe assertion into exactly one VDP request with an ACK handshake.
- Bit-reverses write data and holds read data stable for the whole CPU read cycle.

---
 rtl/vdp_host_bus_if_pkg.sv | 27 ++
 rtl/vdp_host_bus_if_if.sv | 16 +
 rtl/vdp_host_bus_if_strobe_sync_filter.sv | 40 ++++
 rtl/vdp_host_bus_if.sv | 159 +++++++++++++++
 tb/tb_vdp_host_bus_if.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_host_bus_if_pkg.sv
// Shared types and helpers for the V9958 host-bus front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vdp_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] VDP_PORT_DATA   = 2'd0;
    localparam logic [1:0] VDP_PORT_CTRL   = 2'd1;
    localparam logic [1:0] VDP_PORT_PAL    = 2'd2;
    localparam logic [1:0] VDP_PORT_REGIND = 2'd3;

    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vdp_host_bus_if_if.sv
// VDP core request port: REQ/WRT/ADR/DBO out, DBI/ACK back.
// Latency: n/a (wiring only).
// Backpressure: requester holds vdp_req until vdp_ack or abort.
interface vdp_core_if;
    logic        vdp_req;
    logic        vdp_wrt;
    logic [15:0] vdp_adr;
    logic [7:0]  vdp_dbo;
    logic [7:0]  vdp_dbi;
    logic        vdp_ack;

    modport master (output vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
                    input  vdp_dbi, vdp_ack);
    modport slave  (input  vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
                    output vdp_dbi, vdp_ack);
endinterface

// File: rtl/vdp_host_bus_if_strobe_sync_filter.sv
// Synchronizer plus agreement filter for one asynchronous active-low strobe.
// Latency: SYNC_STAGES + FILTER_LEN + 1 edges from raw change to filtered change.
// Backpressure: none; pulses shorter than FILTER_LEN samples never reach the output.
module strobe_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic clk,
    input  logic rst_n_w,
    input  logic raw,
    output logic filtered
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTER_LEN-1:0]  hist_q;

    always_ff @(posedge clk or negedge rst_n_w) begin
        if (!rst_n_w) begin
            sync_q   <= '1;
            hist_q   <= '1;
            filtered <= 1'b1;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q[0] <= sync_q[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            // Mixed history means the line is still settling: keep the old level.
            if (&hist_q) begin
                filtered <= 1'b1;
            end else if (~|hist_q) begin
                filtered <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vdp_host_bus_if.sv
// TMS9900-style CPU strobes to V9958 core REQ/ACK port, one request per strobe assertion.
// Latency: raw strobe low to vdp_req high in SYNC_STAGES+FILTER_LEN+2 clk edges.
// Backpressure: waits up to ACK_TIMEOUT cycles for vdp_ack, then aborts with err_timeout.
module vdp_host_bus_if
    import vdp_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n_w,
    input  logic         csr_n,
    input  logic         csw_n,
    input  logic [1:0]   mode,
    input  logic [0:7]   cd_in,
    output logic [0:7]   cd_out,
    output logic         cd_oe,
    vdp_core_if.master   vdp,
    output logic         busy,
    output logic         err_timeout,
    output logic         err_overlap
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    logic rd_f, wr_f;
    logic [1:0] cs_now;

    state_t           state_q, state_d;
    logic [1:0]       cs_latch_q, cs_latch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             req_q, req_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      adr_q, adr_d;
    logic [7:0]       dbo_q, dbo_d;
    logic [7:0]       rd_hold_q, rd_hold_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_ovl_q, err_ovl_d;

    strobe_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_rd_filt (
        .clk      (clk),
        .rst_n_w  (rst_n_w),
        .raw      (csr_n),
        .filtered (rd_f)
    );

    strobe_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_wr_filt (
        .clk      (clk),
        .rst_n_w  (rst_n_w),
        .raw      (csw_n),
        .filtered (wr_f)
    );

    assign cs_now  = {rd_f, wr_f};
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n_w) begin
        if (!rst_n_w) begin
            state_q    <= IDLE;
            cs_latch_q <= 2'b11;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            wrt_q      <= 1'b0;
            adr_q      <= '0;
            dbo_q      <= '0;
            rd_hold_q  <= '0;
            err_tmo_q  <= 1'b0;
            err_ovl_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_latch_q <= cs_latch_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            wrt_q      <= wrt_d;
            adr_q      <= adr_d;
            dbo_q      <= dbo_d;
            rd_hold_q  <= rd_hold_d;
            err_tmo_q  <= err_tmo_d;
            err_ovl_q  <= err_ovl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_latch_d = cs_latch_q;
        cnt_d      = cnt_q;
        wrt_d      = wrt_q;
        adr_d      = adr_q;
        dbo_d      = dbo_q;
        rd_hold_d  = rd_hold_q;
        err_tmo_d  = 1'b0;
        err_ovl_d  = 1'b0;
        req_d      = 1'b0;

        case (state_q)
            IDLE: begin
                rd_hold_d = vdp.vdp_dbi;
                cnt_d     = '0;
                if (!rd_f || !wr_f) begin
                    cs_latch_d = cs_now;
                    adr_d      = {14'b0, mode};
                end
                if (!rd_f && !wr_f) begin
                    err_ovl_d = 1'b1;
                    state_d   = RELEASE;
                end else if (!rd_f) begin
                    wrt_d   = 1'b0;
                    state_d = REQ;
                end else if (!wr_f) begin
                    wrt_d   = 1'b1;
                    dbo_d   = bitrev8(cd_in);
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = '0;
                if (vdp.vdp_ack) begin
                    if (!wrt_q) rd_hold_d = vdp.vdp_dbi;
                    state_d = RELEASE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (vdp.vdp_ack) begin
                    if (!wrt_q) rd_hold_d = vdp.vdp_dbi;
                    state_d = RELEASE;
                end else if (cnt_inc == CNT_MAX) begin
                    err_tmo_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                // Only a change of the filtered pair re-arms, so a held strobe issues one request.
                if (cs_now != cs_latch_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == REQ) || (state_d == WAIT);
        if (!req_d) wrt_d = 1'b0;
    end

    // Ascending cd range: cd_out[0] (CPU MSB) carries rd_hold_q[7].
    assign cd_out = rd_hold_q;
    assign cd_oe  = ~csr_n & csw_n;
    assign busy   = (state_q != IDLE);

    assign vdp.vdp_req = req_q;
    assign vdp.vdp_wrt = wrt_q;
    assign vdp.vdp_adr = adr_q;
    assign vdp.vdp_dbo = dbo_q;
    assign err_timeout = err_tmo_q;
    assign err_overlap = err_ovl_q;

endmodule

// File: tb/tb_vdp_host_bus_if.sv
// Bench for vdp_host_bus_if: table of CPU accesses checked through a request scoreboard,
// plus hand sequences for glitch, overlap and mid-access reset.
module tb_vdp_host_bus_if;
    import vdp_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n_w = 1'b0;
    logic       csr_n = 1'b1;
    logic       csw_n = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [0:7] cd_in = '0;
    logic [0:7] cd_out;
    logic       cd_oe;
    logic       busy;
    logic       err_timeout;
    logic       err_overlap;

    vdp_core_if vif ();

    vdp_host_bus_if dut (
        .clk         (clk),
        .rst_n_w     (rst_n_w),
        .csr_n       (csr_n),
        .csw_n       (csw_n),
        .mode        (mode),
        .cd_in       (cd_in),
        .cd_out      (cd_out),
        .cd_oe       (cd_oe),
        .vdp         (vif.master),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overlap (err_overlap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [1:0]  mode;
        logic [7:0]  cd;
        logic [7:0]  dbi;
        int          ack_on;   // req cycle on which ack is given, 0 = never
        int          hold;     // cycles the strobe stays low
        bit          exp_wrt;
        logic [15:0] exp_adr;
        logic [7:0]  exp_dbo;
        logic [7:0]  exp_cdout;
        int          exp_req;
        int          exp_tmo;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_access(input int idx, input vec_t v);
        vec_t e;
        int   edge_n = 0, first_edge = -1, req_cyc = 0, rises = 0, tmo = 0;
        int   ack_at = -1, w = 0;
        bit   prev_req = 0, hold_bad = 0;
        string p;
        p = $sformatf("v%0d_", idx);

        @(negedge clk);
        mode         = v.mode;
        cd_in        = v.cd;
        vif.vdp_dbi  = ~v.dbi;
        vif.vdp_ack  = 1'b0;
        if (v.wr) csw_n = 1'b0; else csr_n = 1'b0;
        sb_q.push_back(v);
        #1;
        if (!v.wr) chk({p, "cd_oe"}, cd_oe, 1);

        for (int c = 0; c < v.hold; c++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            vif.vdp_ack = 1'b0;
            if (err_timeout) tmo++;
            if (vif.vdp_req && !prev_req) begin
                rises++;
                if (first_edge < 0) first_edge = edge_n;
                if (sb_q.size() == 0) begin
                    chk({p, "sb_extra_req"}, 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk({p, "wrt"}, vif.vdp_wrt, e.exp_wrt);
                    chk({p, "adr"}, vif.vdp_adr, e.exp_adr);
                    if (e.wr) chk({p, "dbo"}, vif.vdp_dbo, e.exp_dbo);
                end
                vif.vdp_dbi = v.dbi;
            end
            if (ack_at >= 0 && c > ack_at && !v.wr) begin
                if (c == ack_at + 1) chk({p, "cd_out"}, cd_out, v.exp_cdout);
                else if (cd_out !== v.exp_cdout) hold_bad = 1;
                vif.vdp_dbi = 8'hFF;
            end
            if (vif.vdp_req) begin
                req_cyc++;
                if (req_cyc == v.ack_on) begin
                    vif.vdp_ack = 1'b1;
                    ack_at = c;
                end
            end
            prev_req = vif.vdp_req;
        end

        chk({p, "latency"}, first_edge, 6);
        chk({p, "req_cycles"}, req_cyc, v.exp_req);
        chk({p, "timeouts"}, tmo, v.exp_tmo);
        if (!v.wr) chk({p, "cd_out_hold"}, hold_bad, 0);
        chk({p, "busy_held"}, busy, 1);

        csw_n = 1'b1;
        csr_n = 1'b1;
        while (busy && w < 30) begin
            @(negedge clk);
            if (vif.vdp_req && !prev_req) rises++;
            prev_req = vif.vdp_req;
            w++;
        end
        chk({p, "busy_drop"}, busy, 0);
        chk({p, "req_rises"}, rises, 1);
        chk({p, "sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ovl_cnt, w;
        bit  seen;

        //            wr mode             cd     dbi   ack hold wrt adr       dbo    cdout  req tmo
        vecs[0] = '{1, VDP_PORT_CTRL,   8'h80, 8'h00, 3, 20, 1, 16'h0001, 8'h01, 8'h00, 3,  0};
        vecs[1] = '{0, VDP_PORT_DATA,   8'h00, 8'h3C, 1, 14, 0, 16'h0000, 8'h00, 8'h3C, 1,  0};
        vecs[2] = '{1, VDP_PORT_PAL,    8'hC1, 8'h00, 2, 16, 1, 16'h0002, 8'h83, 8'h00, 2,  0};
        vecs[3] = '{0, VDP_PORT_REGIND, 8'h00, 8'h96, 4, 16, 0, 16'h0003, 8'h00, 8'h96, 4,  0};
        vecs[4] = '{1, VDP_PORT_REGIND, 8'h0F, 8'h00, 1, 14, 1, 16'h0003, 8'hF0, 8'h00, 1,  0};
        vecs[5] = '{1, VDP_PORT_CTRL,   8'h12, 8'h00, 0, 30, 1, 16'h0001, 8'h48, 8'h00, 16, 1};

        vif.vdp_dbi = 8'h00;
        vif.vdp_ack = 1'b0;

        #3;
        chk("rst_req", vif.vdp_req, 0);
        chk("rst_wrt", vif.vdp_wrt, 0);
        chk("rst_adr", vif.vdp_adr, 0);
        chk("rst_dbo", vif.vdp_dbo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_timeout, err_overlap}, 0);
        repeat (2) @(negedge clk);
        rst_n_w = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_access(i, vecs[i]);
        end

        // One-cycle write glitch with a stray ack in IDLE: nothing may happen.
        @(negedge clk);
        vif.vdp_ack = 1'b1;
        csw_n = 1'b0;
        @(negedge clk);
        csw_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (vif.vdp_req || busy) seen = 1;
        end
        chk("glitch_none", seen, 0);
        vif.vdp_ack = 1'b0;

        // Both strobes on the same edge.
        @(negedge clk);
        csr_n = 1'b0;
        csw_n = 1'b0;
        #1;
        chk("ovl_cd_oe", cd_oe, 0);
        ovl_cnt = 0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (err_overlap) ovl_cnt++;
            if (vif.vdp_req) seen = 1;
        end
        chk("ovl_pulses", ovl_cnt, 1);
        chk("ovl_no_req", seen, 0);
        chk("ovl_busy", busy, 1);
        csr_n = 1'b1;
        csw_n = 1'b1;
        w = 0;
        while (busy && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("ovl_busy_drop", busy, 0);

        // Asynchronous reset while waiting for ack.
        @(negedge clk);
        mode  = VDP_PORT_DATA;
        cd_in = 8'hFF;
        csw_n = 1'b0;
        w = 0;
        while (!vif.vdp_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("rstw_req_pre", vif.vdp_req, 1);
        chk("rstw_dbo_pre", vif.vdp_dbo, 8'hFF);
        #2;
        rst_n_w = 1'b0;
        #1;
        chk("rstw_req", vif.vdp_req, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_dbo", vif.vdp_dbo, 0);
        csw_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n_w = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || vif.vdp_req) seen = 1;
        end
        chk("rstw_idle", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
